// File: rtl/writeback_regfile_pipe.sv
`default_nettype none
// ============================================================================
// Module   : writeback_regfile_pipe
// Brief    : Y86-64 write-back stage, 15x64 register file, sticky status and
//            saturating retired-instruction counter.
// Revision : 1.0 - initial release
// ============================================================================
module writeback_regfile_pipe #(
  parameter logic [63:0] RSP_INIT = 64'h0,
  parameter int          RET_W    = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       W_stat,
  input  logic [3:0]       W_icode,
  input  logic [3:0]       W_dstE,
  input  logic [63:0]      W_valE,
  input  logic [3:0]       W_dstM,
  input  logic [63:0]      W_valM,
  output logic [63:0]      reg_file0,
  output logic [63:0]      reg_file1,
  output logic [63:0]      reg_file2,
  output logic [63:0]      reg_file3,
  output logic [63:0]      reg_file4,
  output logic [63:0]      reg_file5,
  output logic [63:0]      reg_file6,
  output logic [63:0]      reg_file7,
  output logic [63:0]      reg_file8,
  output logic [63:0]      reg_file9,
  output logic [63:0]      reg_file10,
  output logic [63:0]      reg_file11,
  output logic [63:0]      reg_file12,
  output logic [63:0]      reg_file13,
  output logic [63:0]      reg_file14,
  output logic [2:0]       stat,
  output logic             halted,
  output logic [RET_W-1:0] retired
);

  localparam logic [2:0] c_stat_bub = 3'd0;
  localparam logic [2:0] c_stat_aok = 3'd1;
  localparam logic [2:0] c_stat_hlt = 3'd2;
  localparam logic [2:0] c_stat_adr = 3'd3;
  localparam logic [2:0] c_stat_ins = 3'd4;

  typedef enum logic [0:0] {
    ST_RUN  = 1'b0,
    ST_STOP = 1'b1
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [2:0]        r_stat;
  logic [2:0]        w_stat_nxt;
  logic [63:0]       r_regs [15];
  logic [RET_W-1:0]  r_retired;
  logic              w_commit;

  assign w_commit = (r_state == ST_RUN) && (W_stat == c_stat_aok);

  // M port wins over E port when both target the same register (popq %rsp).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < 15; k++) begin
        r_regs[k] <= (k == 4) ? RSP_INIT : 64'h0;
      end
    end else if (w_commit) begin
      for (int k = 0; k < 15; k++) begin
        if (W_dstM == 4'(k)) begin
          r_regs[k] <= W_valM;
        end else if (W_dstE == 4'(k)) begin
          r_regs[k] <= W_valE;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_retired <= '0;
    end else if (w_commit && (W_icode != 4'h0) && (r_retired != '1)) begin
      r_retired <= r_retired + RET_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_RUN;
      r_stat  <= c_stat_aok;
    end else begin
      r_state <= w_state_nxt;
      r_stat  <= w_stat_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_stat_nxt  = r_stat;
    if (r_state == ST_RUN) begin
      case (W_stat)
        c_stat_bub, c_stat_aok: begin
          w_stat_nxt = c_stat_aok;
        end
        c_stat_hlt, c_stat_adr, c_stat_ins: begin
          w_stat_nxt  = W_stat;
          w_state_nxt = ST_STOP;
        end
        default: begin
          w_stat_nxt  = c_stat_ins;
          w_state_nxt = ST_STOP;
        end
      endcase
    end
  end

  assign stat    = r_stat;
  assign halted  = (r_state == ST_STOP);
  assign retired = r_retired;

  assign reg_file0  = r_regs[0];
  assign reg_file1  = r_regs[1];
  assign reg_file2  = r_regs[2];
  assign reg_file3  = r_regs[3];
  assign reg_file4  = r_regs[4];
  assign reg_file5  = r_regs[5];
  assign reg_file6  = r_regs[6];
  assign reg_file7  = r_regs[7];
  assign reg_file8  = r_regs[8];
  assign reg_file9  = r_regs[9];
  assign reg_file10 = r_regs[10];
  assign reg_file11 = r_regs[11];
  assign reg_file12 = r_regs[12];
  assign reg_file13 = r_regs[13];
  assign reg_file14 = r_regs[14];

endmodule
`default_nettype wire

// File: tb/tb_writeback_regfile_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_writeback_regfile_pipe
// Brief    : Self-checking bench for writeback_regfile_pipe against a
//            behavioural register-file / status / counter model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_writeback_regfile_pipe;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  W_stat  = 3'd0;
  logic [3:0]  W_icode = 4'd0;
  logic [3:0]  W_dstE  = 4'hF;
  logic [63:0] W_valE  = 64'h0;
  logic [3:0]  W_dstM  = 4'hF;
  logic [63:0] W_valM  = 64'h0;

  logic [63:0] rf  [15];
  logic [63:0] rf2 [15];
  logic [2:0]  stat, stat2;
  logic        halted, halted2;
  logic [31:0] retired;
  logic [3:0]  retired2;

  // Behavioural model
  logic [63:0] m_regs [15];
  logic [2:0]  m_stat;
  logic        m_halted;
  int          m_ret;
  int          m_ret2;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  writeback_regfile_pipe #(.RSP_INIT(64'h200), .RET_W(32)) dut (
    .clk(clk), .rst(rst), .W_stat(W_stat), .W_icode(W_icode),
    .W_dstE(W_dstE), .W_valE(W_valE), .W_dstM(W_dstM), .W_valM(W_valM),
    .reg_file0(rf[0]),   .reg_file1(rf[1]),   .reg_file2(rf[2]),
    .reg_file3(rf[3]),   .reg_file4(rf[4]),   .reg_file5(rf[5]),
    .reg_file6(rf[6]),   .reg_file7(rf[7]),   .reg_file8(rf[8]),
    .reg_file9(rf[9]),   .reg_file10(rf[10]), .reg_file11(rf[11]),
    .reg_file12(rf[12]), .reg_file13(rf[13]), .reg_file14(rf[14]),
    .stat(stat), .halted(halted), .retired(retired)
  );

  writeback_regfile_pipe #(.RSP_INIT(64'h200), .RET_W(4)) dut_sat (
    .clk(clk), .rst(rst), .W_stat(W_stat), .W_icode(W_icode),
    .W_dstE(W_dstE), .W_valE(W_valE), .W_dstM(W_dstM), .W_valM(W_valM),
    .reg_file0(rf2[0]),   .reg_file1(rf2[1]),   .reg_file2(rf2[2]),
    .reg_file3(rf2[3]),   .reg_file4(rf2[4]),   .reg_file5(rf2[5]),
    .reg_file6(rf2[6]),   .reg_file7(rf2[7]),   .reg_file8(rf2[8]),
    .reg_file9(rf2[9]),   .reg_file10(rf2[10]), .reg_file11(rf2[11]),
    .reg_file12(rf2[12]), .reg_file13(rf2[13]), .reg_file14(rf2[14]),
    .stat(stat2), .halted(halted2), .retired(retired2)
  );

  task automatic model_reset();
    for (int k = 0; k < 15; k++) m_regs[k] = (k == 4) ? 64'h200 : 64'h0;
    m_stat   = 3'd1;
    m_halted = 1'b0;
    m_ret    = 0;
    m_ret2   = 0;
  endtask

  // Called at a negedge; drives one W record, lets one rising edge pass and
  // returns at the following negedge with the model advanced.
  task automatic step(input logic [2:0] s, input logic [3:0] ic,
                      input logic [3:0] de, input logic [63:0] ve,
                      input logic [3:0] dm, input logic [63:0] vm);
    W_stat = s; W_icode = ic; W_dstE = de; W_valE = ve; W_dstM = dm; W_valM = vm;
    @(posedge clk);
    if (!m_halted) begin
      if (s == 3'd1) begin
        if (de != 4'hF) m_regs[de] = ve;
        if (dm != 4'hF) m_regs[dm] = vm;
        if (ic != 4'h0) begin
          m_ret++;
          if (m_ret2 < 15) m_ret2++;
        end
      end else if (s != 3'd0) begin
        m_halted = 1'b1;
        m_stat   = (s > 3'd4) ? 3'd4 : s;
      end
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    for (int k = 0; k < 15; k++) begin
      n_cmp++;
      if (rf[k] !== m_regs[k]) begin
        n_bad++; $display("FAIL reset_reg%0d got %h exp %h", k, rf[k], m_regs[k]);
      end
    end
    n_cmp++; if (stat !== 3'd1) begin n_bad++; $display("FAIL reset_stat got %0d exp 1", stat); end
    n_cmp++; if (halted !== 1'b0) begin n_bad++; $display("FAIL reset_halted got %b exp 0", halted); end
    n_cmp++; if (retired !== 32'd0) begin n_bad++; $display("FAIL reset_retired got %0d exp 0", retired); end
    n_cmp++; if (retired2 !== 4'd0) begin n_bad++; $display("FAIL reset_retired_sat got %0d exp 0", retired2); end
  endtask

  task automatic test_dual_write();
    W_stat = 3'd1; W_icode = 4'd6; W_dstE = 4'd3; W_valE = 64'h11; W_dstM = 4'd7; W_valM = 64'h22;
    #1;
    n_cmp++; if (rf[3] !== 64'h0) begin n_bad++; $display("FAIL no_readthrough got %h exp 0", rf[3]); end
    step(3'd1, 4'd6, 4'd3, 64'h11, 4'd7, 64'h22);
    n_cmp++; if (rf[3] !== 64'h11) begin n_bad++; $display("FAIL dual_e got %h exp 11", rf[3]); end
    n_cmp++; if (rf[7] !== 64'h22) begin n_bad++; $display("FAIL dual_m got %h exp 22", rf[7]); end
    n_cmp++; if (retired !== 32'd1) begin n_bad++; $display("FAIL dual_retired got %0d exp 1", retired); end
  endtask

  task automatic test_conflict();
    step(3'd1, 4'hB, 4'd4, 64'h108, 4'd4, 64'hABCD);
    n_cmp++; if (rf[4] !== 64'hABCD) begin n_bad++; $display("FAIL conflict got %h exp abcd", rf[4]); end
    n_cmp++; if (retired !== 32'd2) begin n_bad++; $display("FAIL conflict_retired got %0d exp 2", retired); end
  endtask

  task automatic test_bubble_nodest();
    step(3'd0, 4'd6, 4'd2, 64'hDEAD, 4'hF, 64'h0);
    n_cmp++; if (rf[2] !== 64'h0) begin n_bad++; $display("FAIL bubble_reg2 got %h exp 0", rf[2]); end
    n_cmp++; if (retired !== 32'd2) begin n_bad++; $display("FAIL bubble_retired got %0d exp 2", retired); end
    step(3'd1, 4'd1, 4'hF, 64'h5555, 4'hF, 64'h6666);
    for (int k = 0; k < 15; k++) begin
      n_cmp++;
      if (rf[k] !== m_regs[k]) begin
        n_bad++; $display("FAIL nodest_reg%0d got %h exp %h", k, rf[k], m_regs[k]);
      end
    end
    n_cmp++; if (retired !== 32'd3) begin n_bad++; $display("FAIL nodest_retired got %0d exp 3", retired); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 200; i++) begin
      logic [2:0] s;
      s = ($urandom_range(0, 3) == 0) ? 3'd0 : 3'd1;
      step(s, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
           {$urandom, $urandom}, 4'($urandom_range(0, 15)), {$urandom, $urandom});
      for (int k = 0; k < 15; k++) begin
        n_cmp++;
        if (rf[k] !== m_regs[k]) begin
          n_bad++; $display("FAIL random%0d_reg%0d got %h exp %h", i, k, rf[k], m_regs[k]);
        end
      end
      n_cmp++;
      if (retired !== 32'(m_ret)) begin
        n_bad++; $display("FAIL random%0d_retired got %0d exp %0d", i, retired, m_ret);
      end
      n_cmp++;
      if (stat !== 3'd1 || halted !== 1'b0) begin
        n_bad++; $display("FAIL random%0d_status got %0d/%b exp 1/0", i, stat, halted);
      end
    end
  endtask

  task automatic test_fault();
    int ret_before;
    do_reset();
    step(3'd1, 4'd2, 4'd5, 64'h77, 4'hF, 64'h0);
    ret_before = m_ret;
    step(3'd3, 4'd5, 4'hF, 64'h0, 4'd5, 64'h99);
    n_cmp++; if (rf[5] !== 64'h77) begin n_bad++; $display("FAIL fault_reg5 got %h exp 77", rf[5]); end
    n_cmp++; if (stat !== 3'd3) begin n_bad++; $display("FAIL fault_stat got %0d exp 3", stat); end
    n_cmp++; if (halted !== 1'b1) begin n_bad++; $display("FAIL fault_halted got %b exp 1", halted); end
    n_cmp++; if (retired !== 32'(ret_before)) begin n_bad++; $display("FAIL fault_retired got %0d exp %0d", retired, ret_before); end
    for (int i = 0; i < 5; i++) begin
      step(($urandom_range(0, 1) == 0) ? 3'd1 : 3'($urandom_range(0, 7)), 4'd6,
           4'd1, {$urandom, $urandom}, 4'd1, {$urandom, $urandom});
      n_cmp++; if (rf[1] !== m_regs[1]) begin n_bad++; $display("FAIL sticky%0d_reg1 got %h exp %h", i, rf[1], m_regs[1]); end
      n_cmp++; if (stat !== 3'd3 || halted !== 1'b1) begin n_bad++; $display("FAIL sticky%0d_status got %0d/%b exp 3/1", i, stat, halted); end
      n_cmp++; if (retired !== 32'(ret_before)) begin n_bad++; $display("FAIL sticky%0d_retired got %0d exp %0d", i, retired, ret_before); end
    end
    // Asynchronous reset out of STOP, checked before any clock edge.
    rst = 1'b1;
    model_reset();
    #1;
    n_cmp++; if (stat !== 3'd1 || halted !== 1'b0) begin n_bad++; $display("FAIL async_rst_status got %0d/%b exp 1/0", stat, halted); end
    n_cmp++; if (rf[5] !== 64'h0 || rf[4] !== 64'h200) begin n_bad++; $display("FAIL async_rst_regs got %h/%h exp 0/200", rf[5], rf[4]); end
    @(negedge clk);
    rst = 1'b0;
    // Each fault code, including 5..7 which map to INS.
    for (int c = 2; c <= 7; c++) begin
      do_reset();
      step(3'(c), 4'd3, 4'd6, 64'h1234, 4'hF, 64'h0);
      n_cmp++;
      if (stat !== m_stat || halted !== 1'b1 || rf[6] !== 64'h0) begin
        n_bad++; $display("FAIL faultcode%0d got stat %0d halted %b reg6 %h exp %0d 1 0", c, stat, halted, rf[6], m_stat);
      end
    end
  endtask

  task automatic test_saturation();
    do_reset();
    for (int i = 1; i <= 20; i++) begin
      step(3'd1, 4'($urandom_range(1, 15)), 4'hF, 64'h0, 4'hF, 64'h0);
      n_cmp++;
      if (retired2 !== 4'(m_ret2)) begin
        n_bad++; $display("FAIL sat%0d_retired4 got %0d exp %0d", i, retired2, m_ret2);
      end
    end
    n_cmp++; if (retired2 !== 4'hF) begin n_bad++; $display("FAIL sat_final got %0d exp 15", retired2); end
    n_cmp++; if (retired !== 32'd20) begin n_bad++; $display("FAIL sat_wide got %0d exp 20", retired); end
    step(3'd0, 4'd6, 4'hF, 64'h0, 4'hF, 64'h0);
    n_cmp++; if (retired2 !== 4'hF) begin n_bad++; $display("FAIL sat_hold got %0d exp 15", retired2); end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_dual_write();
    test_conflict();
    test_bubble_nodest();
    test_random();
    test_fault();
    test_saturation();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL timeout got running exp finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
